// File: rtl/if_fetch_if.sv
// -----------------------------------------------------------------------------
// if_fetch_if : instruction-ROM bus between the fetch stage and the ROM.
//   rom_ce   - chip enable, driven by the fetch stage
//   rom_addr - byte address, driven by the fetch stage
//   rom_inst - instruction word at rom_addr>>2, returned combinationally
// Modports: master (fetch stage), slave (ROM).
// -----------------------------------------------------------------------------
interface if_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_inst;

   modport master (output rom_ce, output rom_addr, input rom_inst);
   modport slave  (input rom_ce, input rom_addr, output rom_inst);
endinterface

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage of the 5-stage RISC-V core.
// Owns the PC, drives the combinational instruction ROM and loads the IF/ID
// pipeline register. Handles stalls, flushes and branch redirects from ID,
// remembering a redirect that arrives while IF is stalled.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   stall_if        - hold the PC
//   stall_id        - hold the IF/ID register
//   flush           - squash IF/ID contents
//   branch_flag     - taken branch/jump redirect from ID
//   branch_target   - redirect address (low two bits cleared on load)
//   rom             - ROM bus (master): rom_ce, rom_addr (= pc), rom_inst
//   id_pc, id_inst  - IF/ID register contents
//   id_valid        - IF/ID holds a real instruction (0 = bubble)
//   if_misalign     - (IF_MISALIGN_EXC_EN) one-cycle pulse on a misaligned
//                     accepted redirect
//   if_badaddr      - (IF_MISALIGN_EXC_EN) unmodified misaligned target
//
// Optional feature macro: IF_MISALIGN_EXC_EN
// -----------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32,
   parameter int          INST_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_if,
   input  logic              stall_id,
   input  logic              flush,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   if_fetch_if.master        rom,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
`ifdef IF_MISALIGN_EXC_EN
   output logic              if_misalign,
   output logic [ADDR_W-1:0] if_badaddr,
`endif
   output logic              id_valid
);

   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_target;
   logic [ADDR_W-1:0] target_aligned;
   logic              bubble;

   assign rom.rom_ce   = ce;
   assign rom.rom_addr = pc;

   // Masking keeps every target bit in use even when the misalign check is
   // compiled out.
   assign target_aligned = branch_target & ~ADDR_W'(3);

   // The fetched word is wrong-path or not fetched at all in any of these cases.
   assign bubble = flush | branch_flag | stall_if | ~ce | pend_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC[ADDR_W-1:0];
         ce          <= 1'b0;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         id_pc       <= '0;
         id_inst     <= '0;
         id_valid    <= 1'b0;
      end else begin
         ce <= 1'b1;

         // PC / pending-redirect update
         if (!ce) begin
            pc <= pc;
         end else if (stall_if) begin
            if (branch_flag) begin
               pend_valid  <= 1'b1;
               pend_target <= target_aligned;
            end
         end else if (branch_flag) begin
            pc         <= target_aligned;
            pend_valid <= 1'b0;
         end else if (pend_valid) begin
            pc         <= pend_target;
            pend_valid <= 1'b0;
         end else begin
            pc <= pc + ADDR_W'(4);
         end

         // IF/ID register update; stall_id dominates flush and redirects
         if (stall_id) begin
            id_pc    <= id_pc;
            id_inst  <= id_inst;
            id_valid <= id_valid;
         end else if (bubble) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
         end else begin
            id_pc    <= pc;
            id_inst  <= rom.rom_inst;
            id_valid <= 1'b1;
         end
      end
   end

`ifdef IF_MISALIGN_EXC_EN
   // A redirect is accepted whenever the fetch stage is enabled, whether it
   // lands in pc directly or is captured as pending during a stall.
   logic misalign_evt;
   assign misalign_evt = ce & branch_flag & (branch_target[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         if_misalign <= 1'b0;
         if_badaddr  <= '0;
      end else begin
         if_misalign <= misalign_evt;
         if (misalign_evt) begin
            if_badaddr <= branch_target;
         end
      end
   end
`endif

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch initiator for the 5-stage RISC-V core.
- Owns the program counter and drives the combinational instruction ROM's `ce`/`addr` interface. The ROM returns the word at `addr>>2` in the same cycle.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles pipeline stalls, flushes and branch/jump redirects from ID, including redirects that arrive while IF is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC / ROM address width (matches `InstAddrBus`).
- INST_W, 32, instruction width (matches `InstBus`).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_if  input  1  hold the PC (from stall controller).
- stall_id  input  1  hold the IF/ID register.
- flush  input  1  squash the IF/ID contents (exception/pipeline flush).
- branch_flag  input  1  taken branch/jump redirect from ID.
- branch_target  input  ADDR_W  redirect address.
- rom_ce  output  1  ROM chip enable.
- rom_addr  output  ADDR_W  ROM byte address; always equals pc.
- rom_inst  input  INST_W  ROM read data, valid in the same cycle as rom_addr.
- id_pc  output  ADDR_W  PC of the instruction in IF/ID.
- id_inst  output  INST_W  instruction in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.

Behaviour:
Reset (rst=1 at edge):
- pc=RESET_PC, rom_ce=0, id_pc=0, id_inst=0, id_valid=0.
- pend_valid=0, pend_target=0.

rom_ce:
- Registered: rom_ce <= ~rst.
- First cycle after rst deasserts: rom_ce=0 and pc=RESET_PC.
- Fetch of RESET_PC occurs in the next cycle.
- While rom_ce=0, pc holds.

PC update, evaluated in priority order at each edge:
1. rst: pc <= RESET_PC.
2. rom_ce=0: hold pc.
3. stall_if=1:
   - Hold pc.
   - If branch_flag=1: pend_valid <= 1, pend_target <= branch_target. A later branch_flag during the same stall overwrites pend_target.
4. branch_flag=1 (not stalled): pc <= branch_target; pend_valid <= 0. A live branch overrides a pending one.
5. pend_valid=1: pc <= pend_target; pend_valid <= 0.
6. Otherwise: pc <= pc+4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0x0000_0000).

Redirect target alignment:
- branch_target[1:0] is forced to 2'b00 whenever it is loaded into pc or pend_target.
- See the optional feature below.

IF/ID register update, evaluated in priority order:
1. rst: cleared, id_valid=0.
2. stall_id=1: hold all three outputs. This holds even if flush or branch_flag is asserted; the stall controller guarantees ID-stage stalls precede flushes.
3. Load a bubble (id_pc=0, id_inst=0, id_valid=0) if any of the following holds:
   - flush=1
   - branch_flag=1 (wrong-path instruction; no delay slot)
   - stall_if=1
   - rom_ce=0
   - pend_valid=1
4. Otherwise: id_pc <= pc, id_inst <= rom_inst, id_valid <= 1.

Latency:
- An instruction at address A appears in IF/ID one edge after pc=A with no stall.
- Redirect penalty is exactly 1 bubble.

Reset mid-operation:
- All state, including the pending redirect, is discarded.
- Fetch resumes at RESET_PC after one rom_ce=0 cycle.

Optional Feature:
Macro IF_MISALIGN_EXC_EN.

When defined:
- Adds outputs if_misalign (1) and if_badaddr (ADDR_W).
- Any redirect accepted with branch_target[1:0]!=0 (live or captured into pending) produces, on the following edge:
  - if_misalign=1 for exactly one cycle;
  - if_badaddr = the unmodified target, held until the next misaligned event.
- pc is still loaded with the target's low bits cleared.
- Reset values: if_misalign=0, if_badaddr=0.

When undefined:
- Ports absent.
- Low bits are cleared silently.

Test Plan:
- Reset then run, ROM word[i]=i+0x100 -> rom_ce 0 for 1 cycle; id_pc = 0, 4, 8 with id_inst = 0x100, 0x101, 0x102, id_valid=1 on consecutive cycles.
- stall_if=1 and stall_id=1 for 3 cycles at pc=0x10 -> pc, id_pc, id_inst constant; on release fetch resumes at 0x10, no skipped or duplicated instruction.
- branch_flag=1, target 0x40, at pc=0x0C -> next cycle pc=0x40, id_valid=0 (one bubble), then id_pc=0x40.
- branch_flag with target 0x80 during stall_if=1 (stall held 2 more cycles) -> pc holds; on release pc=0x80, exactly one bubble, then id_pc=0x80.
- pc=0xFFFF_FFFC free-running -> next pc=0x0000_0000; rst asserted mid-stream with a pending redirect -> pending discarded, id_valid=0, fetch restarts at RESET_PC.
- IF_MISALIGN_EXC_EN: branch target 0x42 -> pc=0x40, if_misalign pulses for 1 cycle, if_badaddr=0x42.
